// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op/state encodings and helpers for the multiply/divide unit
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD,
        OP_MADDU, OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO
    } mdu_op_e;

    typedef enum logic [2:0] {IDLE, MUL, DIV, MOVE, DONE} mdu_state_e;

    localparam int DIV_ITER = 32;

    function automatic logic is_signed_op(mdu_op_e op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

endpackage

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - 32-iteration restoring divider: one sign-prep cycle, then one quotient bit per cycle
module div_radix2
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        start,
    input  logic        signed_i,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    typedef enum logic [1:0] {D_IDLE, D_PREP, D_ITER} div_phase_e;

    div_phase_e  phase;
    logic [5:0]  cnt;
    logic [31:0] a_r, b_r, d_mag, q_r, r_r;
    logic        sgn_r;

    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] q_next, r_next;
    logic        neg_q, neg_r;

    function automatic logic [31:0] magnitude(logic [31:0] v, logic s);
        return (s && v[31]) ? -v : v;
    endfunction

    always_comb begin
        rem_sh = {r_r, q_r[31]};
        ge     = rem_sh >= {1'b0, d_mag};
        r_next = ge ? 32'(rem_sh - {1'b0, d_mag}) : rem_sh[31:0];
        q_next = {q_r[30:0], ge};
        neg_q  = sgn_r & (a_r[31] ^ b_r[31]);
        neg_r  = sgn_r & a_r[31];
    end

    // Results are taken straight off the final iteration so the caller can capture them on that edge.
    assign done = (phase == D_ITER) && (cnt == 6'(DIV_ITER - 1));
    assign quot = (b_r == 32'd0) ? 32'hFFFF_FFFF : (neg_q ? -q_next : q_next);
    assign rem  = (b_r == 32'd0) ? a_r : (neg_r ? -r_next : r_next);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase <= D_IDLE;
            cnt   <= 6'd0;
            a_r   <= 32'd0;
            b_r   <= 32'd0;
            sgn_r <= 1'b0;
            d_mag <= 32'd0;
            q_r   <= 32'd0;
            r_r   <= 32'd0;
        end else if (flush) begin
            phase <= D_IDLE;
            cnt   <= 6'd0;
        end else begin
            case (phase)
                D_IDLE: if (start) begin
                    a_r   <= a;
                    b_r   <= b;
                    sgn_r <= signed_i;
                    phase <= D_PREP;
                end
                D_PREP: begin
                    q_r   <= magnitude(a_r, sgn_r);
                    d_mag <= magnitude(b_r, sgn_r);
                    r_r   <= 32'd0;
                    cnt   <= 6'd0;
                    phase <= D_ITER;
                end
                D_ITER: begin
                    q_r <= q_next;
                    r_r <= r_next;
                    cnt <= cnt + 6'd1;
                    if (done) phase <= D_IDLE;
                end
                default: phase <= D_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MULT/DIV/MADD/MSUB/MTHI/MTLO unit producing {HI,LO} write data
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush_i,
    input  logic        start_i,
    input  mdu_op_e     op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [63:0] hilo_cur_i,
    output logic        stall_o,
    output logic        hilo_wen_o,
    output logic [63:0] hilo_o
);

    localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);

    mdu_state_e  state, work;
    mdu_op_e     op_r;
    logic [31:0] a_r, b_r;
    logic [63:0] cur_r;
    logic [7:0]  mul_cnt;

    logic [63:0] a64, b64, prod, mul_result, move_result;
    logic        accept;
    logic        div_done;
    logic [31:0] div_quot, div_rem;

    always_comb begin
        work = IDLE;
        case (op_i)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: work = MUL;
            OP_DIV, OP_DIVU:                                         work = DIV;
            OP_MTHI, OP_MTLO:                                        work = MOVE;
            default:                                                 work = IDLE;
        endcase
    end

    assign accept     = (state == IDLE) && start_i && !flush_i && (work != IDLE);
    assign stall_o    = start_i && !flush_i && ((state == IDLE) ? (work != IDLE) : (state != DONE));
    assign hilo_wen_o = (state == DONE) && !flush_i;

    // Low 64 bits of the product of sign/zero-extended operands give both signed and unsigned results.
    always_comb begin
        a64  = {{32{is_signed_op(op_r) & a_r[31]}}, a_r};
        b64  = {{32{is_signed_op(op_r) & b_r[31]}}, b_r};
        prod = a64 * b64;
        case (op_r)
            OP_MADD, OP_MADDU: mul_result = cur_r + prod;
            OP_MSUB, OP_MSUBU: mul_result = cur_r - prod;
            default:           mul_result = prod;
        endcase
        move_result = (op_r == OP_MTHI) ? {a_r, cur_r[31:0]} : {cur_r[63:32], a_r};
    end

    div_radix2 u_div (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush_i),
        .start    (accept && (work == DIV)),
        .signed_i (is_signed_op(op_i)),
        .a        (rs_i),
        .b        (rt_i),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            op_r    <= OP_NOP;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            cur_r   <= 64'd0;
            mul_cnt <= 8'd0;
            hilo_o  <= 64'd0;
        end else if (flush_i) begin
            state   <= IDLE;
            mul_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_r    <= op_i;
                    a_r     <= rs_i;
                    b_r     <= rt_i;
                    cur_r   <= hilo_cur_i;
                    mul_cnt <= 8'd0;
                    state   <= work;
                end
                MUL: begin
                    if (mul_cnt == MUL_LAST) begin
                        hilo_o <= mul_result;
                        state  <= DONE;
                    end else begin
                        mul_cnt <= mul_cnt + 8'd1;
                    end
                end
                DIV: if (div_done) begin
                    hilo_o <= {div_rem, div_quot};
                    state  <= DONE;
                end
                MOVE: begin
                    hilo_o <= move_result;
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit against an arithmetic model
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int MUL_CYCLES = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush_i;
    logic        start_i;
    mdu_op_e     op_i;
    logic [31:0] rs_i, rt_i;
    logic [63:0] hilo_cur_i;
    logic        stall_o, hilo_wen_o;
    logic [63:0] hilo_o;

    int n_vec = 0;
    int n_err = 0;

    mul_div_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush_i    (flush_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs_i       (rs_i),
        .rt_i       (rt_i),
        .hilo_cur_i (hilo_cur_i),
        .stall_o    (stall_o),
        .hilo_wen_o (hilo_wen_o),
        .hilo_o     (hilo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(mdu_op_e op, logic [31:0] rs, logic [31:0] rt, logic [63:0] cur);
        logic   sgn;
        longint a, b, q, r;
        sgn = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
        a = sgn ? longint'($signed(rs)) : longint'({32'd0, rs});
        b = sgn ? longint'($signed(rt)) : longint'({32'd0, rt});
        case (op)
            OP_MULT, OP_MULTU: return a * b;
            OP_MADD, OP_MADDU: return cur + a * b;
            OP_MSUB, OP_MSUBU: return cur - a * b;
            OP_DIV, OP_DIVU: begin
                if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
                q = a / b;
                r = a % b;
                return {r[31:0], q[31:0]};
            end
            OP_MTHI: return {rs, cur[31:0]};
            OP_MTLO: return {cur[63:32], rs};
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_latency(mdu_op_e op);
        if (op == OP_MTHI || op == OP_MTLO) return 1;
        if (op == OP_DIV || op == OP_DIVU) return 33;
        return MUL_CYCLES;
    endfunction

    task automatic run_op(input mdu_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [63:0] cur, input logic [63:0] exp);
        int n, stalls;
        @(negedge clk);
        start_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt; hilo_cur_i = cur;
        #1 check("accept_stall", stall_o, 1);
        @(posedge clk); #1;
        stalls = 1;
        n = 0;
        while (!hilo_wen_o && n < 100) begin
            if (stall_o) stalls++;
            @(negedge clk);
            rs_i = $urandom; rt_i = $urandom; hilo_cur_i = {$urandom, $urandom};
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("latency op%0d", op), n, ref_latency(op));
        check("stall_cycles", stalls, ref_latency(op) + 1);
        check("done_stall", stall_o, 0);
        check($sformatf("hilo op%0d rs=%h rt=%h", op, rs, rt), hilo_o, exp);
        @(negedge clk);
        start_i = 1'b0; op_i = OP_NOP;
        @(posedge clk); #1 check("one_strobe", hilo_wen_o, 0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (hilo_wen_o) seen++;
        end
        check(tag, seen, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300));
        return $urandom;
    endfunction

    initial begin
        mdu_op_e     op;
        logic [31:0] ra, rb;
        logic [63:0] rc;

        resetn = 1'b0; flush_i = 1'b0; start_i = 1'b0; op_i = OP_NOP;
        rs_i = 32'd0; rt_i = 32'd0; hilo_cur_i = 64'd0;
        repeat (3) @(posedge clk);
        #1 check("rst_hilo", hilo_o, 0);
        check("rst_wen", hilo_wen_o, 0);
        check("rst_stall", stall_o, 0);
        @(negedge clk) resetn = 1'b1;

        run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 64'd0, 64'h0000_0002_FFFF_FFFA);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(OP_DIVU,  32'd100,       32'd7, 64'd0, 64'h0000_0002_0000_000E);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000);
        run_op(OP_DIVU,  32'd5,         32'd0, 64'd0, 64'h0000_0005_FFFF_FFFF);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0, 64'd0, 64'hFFFF_FFF9_FFFF_FFFF);
        run_op(OP_MADD,  32'h1_0000, 32'h1_0000, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000);
        run_op(OP_MSUBU, 32'd1, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(OP_MTHI,  32'hDEAD_BEEF, 32'd0, 64'h1111_1111_2222_2222, 64'hDEAD_BEEF_2222_2222);

        // NOP with start held must neither stall nor strobe
        @(negedge clk);
        start_i = 1'b1; op_i = OP_NOP;
        #1 check("nop_stall", stall_o, 0);
        expect_quiet("nop_quiet", 4);
        @(negedge clk) start_i = 1'b0;

        // flush ten cycles into a DIVU
        @(negedge clk);
        start_i = 1'b1; op_i = OP_DIVU; rs_i = 32'd1000; rt_i = 32'd3;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk) flush_i = 1'b1;
        #1 check("flush_stall", stall_o, 0);
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0; op_i = OP_NOP;
        expect_quiet("flush_quiet", 40);
        run_op(OP_MULT, 32'h1234, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_EDCC);

        // flush landing in the DONE cycle suppresses the strobe
        @(negedge clk);
        start_i = 1'b1; op_i = OP_MTLO; rs_i = 32'h55; hilo_cur_i = 64'd0;
        @(posedge clk);
        @(posedge clk); #1;
        flush_i = 1'b1;
        #1 check("done_flush_wen", hilo_wen_o, 0);
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0; op_i = OP_NOP;
        expect_quiet("done_flush_quiet", 5);

        // async reset in the middle of a DIV
        run_op(OP_MTHI, 32'hCAFE_F00D, 32'd0, 64'd0, 64'hCAFE_F00D_0000_0000);
        @(negedge clk);
        start_i = 1'b1; op_i = OP_DIV; rs_i = 32'd77; rt_i = 32'd5;
        repeat (6) @(posedge clk);
        #2 resetn = 1'b0;
        #1 check("midrst_hilo", hilo_o, 0);
        check("midrst_wen", hilo_wen_o, 0);
        start_i = 1'b0; op_i = OP_NOP;
        @(negedge clk) resetn = 1'b1;
        expect_quiet("midrst_quiet", 40);
        run_op(OP_MTLO, 32'h1234, 32'd0, 64'hAAAA_AAAA_0000_0000, 64'hAAAA_AAAA_0000_1234);

        for (int i = 0; i < 40; i++) begin
            op = mdu_op_e'($urandom_range(1, 10));
            ra = pick_operand();
            rb = pick_operand();
            rc = {$urandom, $urandom};
            run_op(op, ra, rb, rc, ref_model(op, ra, rb, rc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
